// File: rtl/fp_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_loader_pkg
// Description : Shared state encodings, field widths and button indices for
//               the fp operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_operand_loader_pkg;

    typedef enum logic [2:0] {
        ST_EXP1  = 3'd0,
        ST_FRAC1 = 3'd1,
        ST_EXP2  = 3'd2,
        ST_FRAC2 = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int EXP_W     = 4;
    localparam int FRAC_W    = 8;
    localparam int BTN_ENTER = 0;
    localparam int BTN_CLEAR = 1;

endpackage
`default_nettype wire

// File: rtl/fp_operand_loader_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Active-low button front end: synchronizer, debouncer and a
//               one-cycle press tick on the released-to-pressed transition.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_tick
);

    logic            r_sync0_q, w_sync0_d;
    logic            r_sync1_q, w_sync1_d;
    logic            r_level_q, w_level_d;
    logic            r_prev_q,  w_prev_d;
    logic            r_tick_q,  w_tick_d;
    logic [DB_W-1:0] r_cnt_q,   w_cnt_d;

    always_comb begin
        w_sync0_d = ~i_btn_n;
        w_sync1_d = r_sync0_q;
        w_level_d = r_level_q;
        w_cnt_d   = r_cnt_q;
        if (r_sync1_q == r_level_q) begin
            w_cnt_d = '0;
        end else if (r_cnt_q == DB_W'(DB_CYCLES - 1)) begin
            w_level_d = ~r_level_q;
            w_cnt_d   = '0;
        end else begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
        // Edge detect on the settled level so only a press produces a tick.
        w_prev_d = r_level_q;
        w_tick_d = r_level_q & ~r_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0_q <= 1'b0;
            r_sync1_q <= 1'b0;
            r_level_q <= 1'b0;
            r_prev_q  <= 1'b0;
            r_tick_q  <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_sync0_q <= w_sync0_d;
            r_sync1_q <= w_sync1_d;
            r_level_q <= w_level_d;
            r_prev_q  <= w_prev_d;
            r_tick_q  <= w_tick_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign o_tick = r_tick_q;

endmodule
`default_nettype wire

// File: rtl/fp_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_loader
// Description : Debounced field-entry FSM capturing two fp operands from
//               switches into stable registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_loader
    import fp_operand_loader_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_W      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        btn,
    input  logic [7:0]        sw,
    output logic              sign1,
    output logic [EXP_W-1:0]  exp1,
    output logic [FRAC_W-1:0] frac1,
    output logic              sign2,
    output logic [EXP_W-1:0]  exp2,
    output logic [FRAC_W-1:0] frac2,
    output logic              op_valid,
    output logic              done_tick,
    output logic [2:0]        step
);

    logic w_enter_tick;
    logic w_clear_tick;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) u_enter_db (
        .clk    (clk),
        .reset  (reset),
        .i_btn_n(btn[BTN_ENTER]),
        .o_tick (w_enter_tick)
    );

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) u_clear_db (
        .clk    (clk),
        .reset  (reset),
        .i_btn_n(btn[BTN_CLEAR]),
        .o_tick (w_clear_tick)
    );

    state_e              r_state_q,     w_state_d;
    logic                r_sign1_q,     w_sign1_d;
    logic [EXP_W-1:0]    r_exp1_q,      w_exp1_d;
    logic [FRAC_W-1:0]   r_frac1_q,     w_frac1_d;
    logic                r_sign2_q,     w_sign2_d;
    logic [EXP_W-1:0]    r_exp2_q,      w_exp2_d;
    logic [FRAC_W-1:0]   r_frac2_q,     w_frac2_d;
    logic                r_op_valid_q,  w_op_valid_d;
    logic                r_done_tick_q, w_done_tick_d;

    always_comb begin
        w_state_d = r_state_q;
        w_sign1_d = r_sign1_q;
        w_exp1_d  = r_exp1_q;
        w_frac1_d = r_frac1_q;
        w_sign2_d = r_sign2_q;
        w_exp2_d  = r_exp2_q;
        w_frac2_d = r_frac2_q;

        // Clear outranks enter; illegal encodings recover the same way.
        if (w_clear_tick) begin
            w_state_d = ST_EXP1;
            w_sign1_d = 1'b0;
            w_exp1_d  = '0;
            w_frac1_d = '0;
            w_sign2_d = 1'b0;
            w_exp2_d  = '0;
            w_frac2_d = '0;
        end else begin
            case (r_state_q)
                ST_EXP1: if (w_enter_tick) begin
                    w_exp1_d  = sw[EXP_W-1:0];
                    w_state_d = ST_FRAC1;
                end
                ST_FRAC1: if (w_enter_tick) begin
                    w_sign1_d = sw[7];
                    w_frac1_d = {1'b1, sw[6:0]};
                    w_state_d = ST_EXP2;
                end
                ST_EXP2: if (w_enter_tick) begin
                    w_exp2_d  = sw[EXP_W-1:0];
                    w_state_d = ST_FRAC2;
                end
                ST_FRAC2: if (w_enter_tick) begin
                    w_sign2_d = sw[7];
                    w_frac2_d = {1'b1, sw[6:0]};
                    w_state_d = ST_DONE;
                end
                ST_DONE: if (w_enter_tick) begin
                    w_state_d = ST_EXP1;
                end
                default: begin
                    w_state_d = ST_EXP1;
                    w_sign1_d = 1'b0;
                    w_exp1_d  = '0;
                    w_frac1_d = '0;
                    w_sign2_d = 1'b0;
                    w_exp2_d  = '0;
                    w_frac2_d = '0;
                end
            endcase
        end

        w_op_valid_d  = (w_state_d == ST_DONE);
        w_done_tick_d = (w_state_d == ST_DONE) && (r_state_q != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_EXP1;
            r_sign1_q     <= 1'b0;
            r_exp1_q      <= '0;
            r_frac1_q     <= '0;
            r_sign2_q     <= 1'b0;
            r_exp2_q      <= '0;
            r_frac2_q     <= '0;
            r_op_valid_q  <= 1'b0;
            r_done_tick_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_sign1_q     <= w_sign1_d;
            r_exp1_q      <= w_exp1_d;
            r_frac1_q     <= w_frac1_d;
            r_sign2_q     <= w_sign2_d;
            r_exp2_q      <= w_exp2_d;
            r_frac2_q     <= w_frac2_d;
            r_op_valid_q  <= w_op_valid_d;
            r_done_tick_q <= w_done_tick_d;
        end
    end

    assign sign1     = r_sign1_q;
    assign exp1      = r_exp1_q;
    assign frac1     = r_frac1_q;
    assign sign2     = r_sign2_q;
    assign exp2      = r_exp2_q;
    assign frac2     = r_frac2_q;
    assign op_valid  = r_op_valid_q;
    assign done_tick = r_done_tick_q;
    assign step      = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_operand_loader
// Description : Self-checking bench: directed table, debounce corner cases
//               and randomized buttons/switches against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_operand_loader;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b11;
    logic [7:0] sw = 8'h00;
    logic       sign1, sign2, op_valid, done_tick;
    logic [3:0] exp1, exp2;
    logic [7:0] frac1, frac2;
    logic [2:0] step;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_operand_loader #(.DB_CYCLES(DB), .DB_W(3)) dut (
        .clk(clk), .reset(reset), .btn(btn), .sw(sw),
        .sign1(sign1), .exp1(exp1), .frac1(frac1),
        .sign2(sign2), .exp2(exp2), .frac2(frac2),
        .op_valid(op_valid), .done_tick(done_tick), .step(step)
    );

    // Reference model: raw-level history per button, a run length of
    // disagreeing samples, and the field-entry rules applied on press ticks.
    bit   m_raw[2][3];
    bit   m_lvl[2][4];
    int   m_run[2];
    int   m_step;
    logic m_s1, m_s2, m_opv, m_dt;
    logic [3:0] m_e1, m_e2;
    logic [7:0] m_f1, m_f2;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) m_raw[b][k] = 1'b0;
            for (int k = 0; k < 4; k++) m_lvl[b][k] = 1'b0;
            m_run[b] = 0;
        end
        m_step = 0; m_opv = 0; m_dt = 0;
        m_s1 = 0; m_e1 = 0; m_f1 = 0; m_s2 = 0; m_e2 = 0; m_f2 = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            bit press[2];
            int prev_step;
            for (int b = 0; b < 2; b++) begin
                bit settled;
                press[b] = m_lvl[b][1] & ~m_lvl[b][2];
                settled  = m_lvl[b][0];
                if (m_raw[b][1] != settled) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        settled  = ~settled;
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_raw[b][2] = m_raw[b][1]; m_raw[b][1] = m_raw[b][0];
                m_raw[b][0] = ~btn[b];
                m_lvl[b][3] = m_lvl[b][2]; m_lvl[b][2] = m_lvl[b][1];
                m_lvl[b][1] = m_lvl[b][0]; m_lvl[b][0] = settled;
            end
            prev_step = m_step;
            if (press[1]) begin
                m_step = 0;
                m_s1 = 0; m_e1 = 0; m_f1 = 0; m_s2 = 0; m_e2 = 0; m_f2 = 0;
            end else if (press[0]) begin
                case (m_step)
                    0: begin m_e1 = sw[3:0]; m_step = 1; end
                    1: begin m_s1 = sw[7]; m_f1 = {1'b1, sw[6:0]}; m_step = 2; end
                    2: begin m_e2 = sw[3:0]; m_step = 3; end
                    3: begin m_s2 = sw[7]; m_f2 = {1'b1, sw[6:0]}; m_step = 4; end
                    default: m_step = 0;
                endcase
            end
            m_opv = (m_step == 4);
            m_dt  = (m_step == 4) && (prev_step != 4);
        end
    end

    task automatic cycle();
        logic [30:0] act, exp_v;
        @(posedge clk);
        #1;
        act   = {step, op_valid, done_tick, sign1, exp1, frac1, sign2, exp2, frac2};
        exp_v = {3'(m_step), m_opv, m_dt, m_s1, m_e1, m_f1, m_s2, m_e2, m_f2};
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp_v);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; btn = 2'b11;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] press;   // bit0 enter, bit1 clear
        logic [7:0] swv;
        logic [2:0] step;
        logic       opv;
        int         dtc;
        logic       s1;
        logic [3:0] e1;
        logic [7:0] f1;
        logic       s2;
        logic [3:0] e2;
        logic [7:0] f2;
    } vec_t;

    vec_t tbl[12];
    int   dt_count;

    task automatic press_btns(input logic [1:0] mask, input logic [7:0] swv);
        dt_count = 0;
        sw  = swv;
        btn = ~mask;
        for (int i = 0; i < 8; i++) begin cycle(); dt_count += int'(done_tick); end
        btn = 2'b11;
        for (int i = 0; i < 10; i++) begin cycle(); dt_count += int'(done_tick); end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, "_step"},  32'(step),     32'(v.step));
        check({tag, "_valid"}, 32'(op_valid), 32'(v.opv));
        check({tag, "_ops"},
              32'({sign1, exp1, frac1, sign2, exp2, frac2}),
              32'({v.s1, v.e1, v.f1, v.s2, v.e2, v.f2}));
    endtask

    initial begin
        int hold[2];
        int tick_cnt;
        logic tick_ok;

        tbl[0]  = '{2'b01, 8'h08, 3'd1, 1'b0, 0, 1'b0, 4'h8, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[1]  = '{2'b01, 8'h2A, 3'd2, 1'b0, 0, 1'b0, 4'h8, 8'hAA, 1'b0, 4'h0, 8'h00};
        tbl[2]  = '{2'b01, 8'h07, 3'd3, 1'b0, 0, 1'b0, 4'h8, 8'hAA, 1'b0, 4'h7, 8'h00};
        tbl[3]  = '{2'b01, 8'hC5, 3'd4, 1'b1, 1, 1'b0, 4'h8, 8'hAA, 1'b1, 4'h7, 8'hC5};
        tbl[4]  = '{2'b01, 8'hFF, 3'd0, 1'b0, 0, 1'b0, 4'h8, 8'hAA, 1'b1, 4'h7, 8'hC5};
        tbl[5]  = '{2'b01, 8'h05, 3'd1, 1'b0, 0, 1'b0, 4'h5, 8'hAA, 1'b1, 4'h7, 8'hC5};
        tbl[6]  = '{2'b10, 8'h55, 3'd0, 1'b0, 0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[7]  = '{2'b01, 8'h03, 3'd1, 1'b0, 0, 1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[8]  = '{2'b01, 8'h81, 3'd2, 1'b0, 0, 1'b1, 4'h3, 8'h81, 1'b0, 4'h0, 8'h00};
        tbl[9]  = '{2'b10, 8'h00, 3'd0, 1'b0, 0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[10] = '{2'b01, 8'h0A, 3'd1, 1'b0, 0, 1'b0, 4'hA, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[11] = '{2'b11, 8'h7F, 3'd0, 1'b0, 0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};

        // Reset state
        do_reset();
        check("reset_step", 32'(step), 32'd0);
        check("reset_flags", 32'({op_valid, done_tick}), 32'd0);
        check("reset_ops", 32'({sign1, exp1, frac1, sign2, exp2, frac2}), 32'd0);

        // Press latency: tick exactly 7 cycles after the raw edge
        sw = 8'h00;
        btn = 2'b10;
        tick_ok = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (dut.u_enter_db.o_tick !== (k == 7)) tick_ok = 1'b0;
        end
        check("press_latency", 32'(tick_ok), 32'd1);
        check("press_step", 32'(step), 32'd1);

        // Release produces no tick
        btn = 2'b11;
        tick_cnt = 0;
        for (int k = 0; k < 14; k++) begin cycle(); tick_cnt += int'(dut.u_enter_db.o_tick); end
        check("release_no_tick", 32'(tick_cnt), 32'd0);

        // Glitch one cycle shorter than the debounce window
        btn = 2'b10;
        tick_cnt = 0;
        for (int k = 0; k < 3; k++) begin cycle(); tick_cnt += int'(dut.u_enter_db.o_tick); end
        btn = 2'b11;
        for (int k = 0; k < 14; k++) begin cycle(); tick_cnt += int'(dut.u_enter_db.o_tick); end
        check("glitch_no_tick", 32'(tick_cnt), 32'd0);
        check("glitch_step", 32'(step), 32'd1);

        // Directed entry table, each followed by switch wiggling that must not disturb outputs
        do_reset();
        for (int i = 0; i < 12; i++) begin
            press_btns(tbl[i].press, tbl[i].swv);
            check_outputs($sformatf("vec%0d", i), tbl[i]);
            check($sformatf("vec%0d_done_ticks", i), 32'(dt_count), 32'(tbl[i].dtc));
            for (int k = 0; k < 6; k++) begin sw = 8'($urandom); cycle(); end
            check_outputs($sformatf("vec%0d_hold", i), tbl[i]);
        end

        // Random buttons, switches and occasional reset
        do_reset();
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 12);
                end else begin
                    hold[b]--;
                end
            end
            sw    = 8'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
